fake_n64_bus_sequencer: RTL and testbench
=========================================

Name: fake_n64_bus_sequencer

Overview:
- Owns the single-wire N64 data line for the fake controller and decides who uses it, and when.
- Watches the receiver's read-state output for a completed INFO/RESET or STATUS command.
- Waits for the console to release the line, then launches the transmitter with the correct response type and holds the line driver enabled until the response finishes.
- Enforces a post-response cooldown and a transmit watchdog; sits between fake_n64_controller_rx and the transmitter/tri-state pad.

Parameters:
READ_STATE_SIZE, 4, width of the receiver read-state bus
PREP_INFO_CODE, 4'h4, read-state value meaning "INFO/RESET response requested"
PREP_STATUS_CODE, 4'h5, read-state value meaning "button STATUS response requested"
TURNAROUND_CYCLES, 8, consecutive high line samples required before driving (>=2)
COOLDOWN_CYCLES, 16, idle cycles after a response before the receiver is re-enabled (>=1)
TIMEOUT_CYCLES, 1024, maximum cycles in TRANSMIT waiting for tx_done (>=2)
CNT_WIDTH, 11, width of the shared delay/timeout counter; must hold TIMEOUT_CYCLES-1

Ports:
sample_clk  input  1  single system clock; all logic on rising edge
reset  input  1  synchronous, active-high
cur_read_state  input  READ_STATE_SIZE  read state from the receiver, synchronous to sample_clk
data_rx  input  1  raw data line; asynchronous, double-flop synchronised internally
tx_ready  input  1  transmitter idle and able to accept a start
tx_done  input  1  one-cycle pulse when the transmitter has sent the last bit and the stop bit
tx_start  output  1  one-cycle pulse launching the transmitter
tx_sel  output  2  response type: 2'b00 none, 2'b01 info, 2'b10 status
tx_byte_count  output  3  response length: 3 for info, 4 for status, 0 for none
drive_en  output  1  enables the open-drain line driver
rx_enable  output  1  receiver may accept command bits
busy  output  1  high in every state except IDLE
timeout_err  output  1  sticky; set on watchdog expiry, cleared on the next accepted request
resp_count  output  8  completed responses; wraps 255->0

Behaviour:
- All outputs are registered.
- Reset values: tx_start=0, tx_sel=0, tx_byte_count=0, drive_en=0, rx_enable=1, busy=0, timeout_err=0, resp_count=0, state=IDLE, counter=0, synchroniser flops=1.
- Reset takes priority over every other event. Reset asserted mid-TRANSMIT drops drive_en at that edge.
- Request detection:
  - cur_read_state is registered once (rs_q); rs_q is registered again (rs_qq).
  - req_info = (rs_q==PREP_INFO_CODE && rs_qq!=PREP_INFO_CODE).
  - req_status is formed the same way using PREP_STATUS_CODE.
  - Requests are acted on only in IDLE. Requests in any other state are dropped, not queued.
  - If both requests are seen together (not reachable from the receiver), info wins.
- IDLE:
  - rx_enable=1, drive_en=0.
  - On a request: latch tx_sel/tx_byte_count, clear timeout_err, counter=0, go to TURNAROUND.
- TURNAROUND:
  - rx_enable=0.
  - Synchronised line high: counter++. Line low: counter=0, so the console must release the line for a full window.
  - When counter==TURNAROUND_CYCLES-1 with the line high and tx_ready=1, go to START.
  - If tx_ready=0, the counter saturates and the state holds until tx_ready rises.
- START:
  - tx_start=1 and drive_en=1 for exactly one cycle.
  - counter=0, go to TRANSMIT.
- TRANSMIT:
  - drive_en=1; counter++ each cycle.
  - On tx_done: resp_count++, counter=0, go to COOLDOWN.
  - Else when counter==TIMEOUT_CYCLES-1: timeout_err=1, counter=0, go to COOLDOWN; resp_count is unchanged.
  - If tx_done and expiry occur in the same cycle, tx_done wins and timeout_err stays 0.
- COOLDOWN:
  - drive_en=0, rx_enable=0.
  - counter++. At COOLDOWN_CYCLES-1, go to IDLE, with rx_enable=1 from the next cycle.
  - tx_sel and tx_byte_count return to 0 on entry to IDLE.
- tx_done seen outside TRANSMIT is ignored.
- Latency, with data_rx already high for >=2 cycles and tx_ready=1:
  - Detection edge E = the first edge at which rs_q holds the prep code.
  - tx_start is high in the cycle following edge E+TURNAROUND_CYCLES+1.
- drive_en never asserts unless the state is START or TRANSMIT.

Test Plan:
- Reset, then cur_read_state 0->4 with line high and tx_ready=1 -> exactly one tx_start pulse at E+9, tx_sel=01, tx_byte_count=3, drive_en high from START until tx_done.
- STATUS request (code 5) with tx_done 40 cycles after tx_start -> tx_sel=10, tx_byte_count=4, resp_count 0->1, drive_en falls the cycle after tx_done, rx_enable returns 16 cycles later.
- Line held low 5 cycles after the request, then high -> tx_start is delayed by a full 8-cycle high window measured from the rising line, not from the request.
- tx_done never arrives -> drive_en drops after 1024 TRANSMIT cycles, timeout_err=1 and stays 1 until the next request, resp_count unchanged.
- Second prep code pulsed during TRANSMIT and COOLDOWN -> no extra tx_start; reset asserted mid-TRANSMIT -> drive_en=0 and all outputs at reset values the next cycle.
- 256 back-to-back info responses -> resp_count wraps to 0; tx_done coincident with the timeout edge -> counted, timeout_err=0.

Source files
------------

// File: rtl/fake_n64_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fake_n64_bus_sequencer
//  Purpose  : Arbitrates the single-wire N64 data line between the command
//             receiver and the response transmitter of the fake controller.
//  Revision : 1.0 - initial release
// ============================================================================
module fake_n64_bus_sequencer #(
    parameter int                         READ_STATE_SIZE   = 4,
    parameter logic [READ_STATE_SIZE-1:0] PREP_INFO_CODE    = 4'h4,
    parameter logic [READ_STATE_SIZE-1:0] PREP_STATUS_CODE  = 4'h5,
    parameter int                         TURNAROUND_CYCLES = 8,
    parameter int                         COOLDOWN_CYCLES   = 16,
    parameter int                         TIMEOUT_CYCLES    = 1024,
    parameter int                         CNT_WIDTH         = 11
) (
    input  logic                       sample_clk,
    input  logic                       reset,
    input  logic [READ_STATE_SIZE-1:0] cur_read_state,
    input  logic                       data_rx,
    input  logic                       tx_ready,
    input  logic                       tx_done,
    output logic                       tx_start,
    output logic [1:0]                 tx_sel,
    output logic [2:0]                 tx_byte_count,
    output logic                       drive_en,
    output logic                       rx_enable,
    output logic                       busy,
    output logic                       timeout_err,
    output logic [7:0]                 resp_count
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_turn  = 3'd1;
    localparam logic [2:0] c_start = 3'd2;
    localparam logic [2:0] c_xmit  = 3'd3;
    localparam logic [2:0] c_cool  = 3'd4;

    localparam logic [1:0] c_sel_none   = 2'b00;
    localparam logic [1:0] c_sel_info   = 2'b01;
    localparam logic [1:0] c_sel_status = 2'b10;
    localparam logic [2:0] c_bytes_info   = 3'd3;
    localparam logic [2:0] c_bytes_status = 3'd4;

    localparam logic [CNT_WIDTH-1:0] c_cnt_one   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_turn_last = CNT_WIDTH'(TURNAROUND_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_cool_last = CNT_WIDTH'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_tmo_last  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [READ_STATE_SIZE-1:0] r_rs_q;
    logic [READ_STATE_SIZE-1:0] r_rs_qq;
    logic                       r_sync1;
    logic                       r_sync2;
    logic [2:0]                 r_state;
    logic [CNT_WIDTH-1:0]       r_cnt;

    logic                       w_req_info;
    logic                       w_req_status;
    logic [2:0]                 w_state_nxt;
    logic [CNT_WIDTH-1:0]       w_cnt_nxt;
    logic [1:0]                 w_sel_nxt;
    logic [2:0]                 w_bytes_nxt;
    logic                       w_terr_nxt;
    logic [7:0]                 w_resp_nxt;

    // Rising-edge detect on the receiver state so a held prep code fires once.
    assign w_req_info   = (r_rs_q == PREP_INFO_CODE)   && (r_rs_qq != PREP_INFO_CODE);
    assign w_req_status = (r_rs_q == PREP_STATUS_CODE) && (r_rs_qq != PREP_STATUS_CODE);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = tx_sel;
        w_bytes_nxt = tx_byte_count;
        w_terr_nxt  = timeout_err;
        w_resp_nxt  = resp_count;
        case (r_state)
            c_idle: begin
                if (w_req_info) begin
                    w_sel_nxt   = c_sel_info;
                    w_bytes_nxt = c_bytes_info;
                    w_terr_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_turn;
                end else if (w_req_status) begin
                    w_sel_nxt   = c_sel_status;
                    w_bytes_nxt = c_bytes_status;
                    w_terr_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_turn;
                end
            end
            c_turn: begin
                // Any low sample restarts the window: the console must fully release.
                if (!r_sync2) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_turn_last) begin
                    if (tx_ready) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_start;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            c_start: begin
                w_cnt_nxt   = '0;
                w_state_nxt = c_xmit;
            end
            c_xmit: begin
                // A completion on the expiry cycle still counts as a good response.
                if (tx_done) begin
                    w_resp_nxt  = resp_count + 8'd1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_cool;
                end else if (r_cnt == c_tmo_last) begin
                    w_terr_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_cool;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            c_cool: begin
                if (r_cnt == c_cool_last) begin
                    w_cnt_nxt   = '0;
                    w_sel_nxt   = c_sel_none;
                    w_bytes_nxt = 3'd0;
                    w_state_nxt = c_idle;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_sel_nxt   = c_sel_none;
                w_bytes_nxt = 3'd0;
                w_state_nxt = c_idle;
            end
        endcase
    end

    // Outputs are decoded from the next state so they align with the state register.
    always_ff @(posedge sample_clk) begin
        if (reset) begin
            r_rs_q        <= '0;
            r_rs_qq       <= '0;
            r_sync1       <= 1'b1;
            r_sync2       <= 1'b1;
            r_state       <= c_idle;
            r_cnt         <= '0;
            tx_start      <= 1'b0;
            tx_sel        <= c_sel_none;
            tx_byte_count <= 3'd0;
            drive_en      <= 1'b0;
            rx_enable     <= 1'b1;
            busy          <= 1'b0;
            timeout_err   <= 1'b0;
            resp_count    <= 8'd0;
        end else begin
            r_rs_q        <= cur_read_state;
            r_rs_qq       <= r_rs_q;
            r_sync1       <= data_rx;
            r_sync2       <= r_sync1;
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            tx_start      <= (w_state_nxt == c_start);
            tx_sel        <= w_sel_nxt;
            tx_byte_count <= w_bytes_nxt;
            drive_en      <= (w_state_nxt == c_start) || (w_state_nxt == c_xmit);
            rx_enable     <= (w_state_nxt == c_idle);
            busy          <= (w_state_nxt != c_idle);
            timeout_err   <= w_terr_nxt;
            resp_count    <= w_resp_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fake_n64_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fake_n64_bus_sequencer
//  Purpose  : Self-checking bench for fake_n64_bus_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fake_n64_bus_sequencer;

    localparam int TURN  = 8;
    localparam int COOL  = 16;
    localparam int TMO   = 1024;
    localparam int BOUND = 200;
    localparam logic [3:0] INFO   = 4'h4;
    localparam logic [3:0] STATUS = 4'h5;

    logic       sample_clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cur_read_state = 4'h0;
    logic       data_rx = 1'b1;
    logic       tx_ready = 1'b1;
    logic       tx_done = 1'b0;
    logic       tx_start;
    logic [1:0] tx_sel;
    logic [2:0] tx_byte_count;
    logic       drive_en;
    logic       rx_enable;
    logic       busy;
    logic       timeout_err;
    logic [7:0] resp_count;

    int checks = 0;
    int failures = 0;
    int edge_n = 0;
    int last_edge = 0;
    bit line_at [0:131071];
    bit ready_at [0:131071];
    logic [7:0] exp_resp = 8'd0;
    logic       exp_terr = 1'b0;

    fake_n64_bus_sequencer dut (
        .sample_clk     (sample_clk),
        .reset          (reset),
        .cur_read_state (cur_read_state),
        .data_rx        (data_rx),
        .tx_ready       (tx_ready),
        .tx_done        (tx_done),
        .tx_start       (tx_start),
        .tx_sel         (tx_sel),
        .tx_byte_count  (tx_byte_count),
        .drive_en       (drive_en),
        .rx_enable      (rx_enable),
        .busy           (busy),
        .timeout_err    (timeout_err),
        .resp_count     (resp_count)
    );

    always #5 sample_clk = ~sample_clk;

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Record the inputs present at each rising edge, then settle past it.
    task automatic tick;
        @(posedge sample_clk);
        line_at[edge_n]  = data_rx;
        ready_at[edge_n] = tx_ready;
        last_edge = edge_n;
        edge_n++;
        #1;
    endtask

    // First edge at which the line, seen through two flops, has been high for a
    // full window since the request was taken, and the transmitter is ready.
    function automatic int exp_start(input int e, input int upto);
        for (int n = e + TURN + 1; n <= upto; n++) begin
            bit ok;
            ok = ready_at[n];
            for (int k = 0; k < TURN; k++)
                if (!line_at[n - k - 2]) ok = 1'b0;
            if (ok) return n;
        end
        return -1;
    endfunction

    task automatic run_txn(input logic [3:0] code, input int low_cycles, input int ready_low,
                           input int done_after, input bit poke);
        int e, s, nd, bad, es;
        logic [1:0] esel;
        logic [2:0] ebytes;
        logic       eterr;
        esel   = (code == INFO) ? 2'b01 : 2'b10;
        ebytes = (code == INFO) ? 3'd3 : 3'd4;
        data_rx = 1'b1; tx_ready = 1'b1; tx_done = 1'b0;
        cur_read_state = code;
        tick;
        e = last_edge;
        s = -1; bad = 0;
        for (int i = 1; i <= BOUND && s < 0; i++) begin
            data_rx  = (i <= low_cycles) ? 1'b0 : 1'b1;
            tx_ready = (i <= ready_low) ? 1'b0 : 1'b1;
            tick;
            if (tx_start === 1'b1) s = last_edge;
            else if (drive_en !== 1'b0 || rx_enable !== 1'b0 || busy !== 1'b1) bad++;
        end
        data_rx = 1'b1; tx_ready = 1'b1; cur_read_state = 4'h0;
        es = exp_start(e, last_edge);
        checks++;
        if (s < 0 || s != es) begin
            failures++;
            $display("FAIL start_edge: got edge %0d expected edge %0d (request edge %0d)", s, es, e);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL turnaround_outputs: %0d bad cycles, expected 0", bad);
        end
        checks++;
        if ({tx_sel, tx_byte_count, drive_en, timeout_err, rx_enable} !== {esel, ebytes, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL start_outputs: sel=%b bytes=%0d drv=%b terr=%b rxen=%b expected sel=%b bytes=%0d drv=1 terr=0 rxen=0",
                     tx_sel, tx_byte_count, drive_en, timeout_err, rx_enable, esel, ebytes);
        end
        if (s < 0) return;

        eterr = (done_after == 0 || done_after > TMO + 1);
        nd    = eterr ? TMO + 1 : done_after;
        bad = 0;
        for (int j = 1; j <= nd; j++) begin
            tx_done = (j == done_after) || (poke && j == 1);
            if (poke) cur_read_state = (j == 3 || j == 4) ? STATUS : 4'h0;
            tick;
            if (j < nd && (drive_en !== 1'b1 || tx_start !== 1'b0 || busy !== 1'b1)) bad++;
        end
        tx_done = 1'b0; cur_read_state = 4'h0;
        if (!eterr) exp_resp = exp_resp + 8'd1;
        exp_terr = eterr;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL transmit_drive: %0d bad cycles, expected 0", bad);
        end
        checks++;
        if ({drive_en, tx_start, resp_count, timeout_err} !== {1'b0, 1'b0, exp_resp, exp_terr}) begin
            failures++;
            $display("FAIL response_end: drv=%b start=%b resp=%0d terr=%b expected drv=0 start=0 resp=%0d terr=%b",
                     drive_en, tx_start, resp_count, timeout_err, exp_resp, exp_terr);
        end

        bad = 0;
        for (int k = 1; k <= COOL; k++) begin
            if (poke) begin
                cur_read_state = (k == 4 || k == 5) ? INFO : 4'h0;
                tx_done = (k == 3);
            end
            tick;
            if (k < COOL && (rx_enable !== 1'b0 || busy !== 1'b1 || drive_en !== 1'b0 || tx_start !== 1'b0)) bad++;
        end
        cur_read_state = 4'h0; tx_done = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL cooldown_outputs: %0d bad cycles, expected 0", bad);
        end
        checks++;
        if ({rx_enable, busy, tx_sel, tx_byte_count, drive_en, timeout_err, resp_count} !==
            {1'b1, 1'b0, 2'b00, 3'd0, 1'b0, exp_terr, exp_resp}) begin
            failures++;
            $display("FAIL idle_return: rxen=%b busy=%b sel=%b bytes=%0d drv=%b terr=%b resp=%0d expected 1 0 00 0 0 %b %0d",
                     rx_enable, busy, tx_sel, tx_byte_count, drive_en, timeout_err, resp_count, exp_terr, exp_resp);
        end
        if (poke) begin
            bad = 0;
            repeat (12) begin
                tick;
                if (tx_start !== 1'b0 || busy !== 1'b0) bad++;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL dropped_request: %0d cycles with activity, expected 0", bad);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; data_rx = 1'b1; tx_ready = 1'b1;
        repeat (3) tick;
        checks++;
        if ({tx_start, tx_sel, tx_byte_count, drive_en, rx_enable, busy, timeout_err, resp_count} !==
            {1'b0, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL reset_values: start=%b sel=%b bytes=%0d drv=%b rxen=%b busy=%b terr=%b resp=%0d",
                     tx_start, tx_sel, tx_byte_count, drive_en, rx_enable, busy, timeout_err, resp_count);
        end
        reset = 1'b0;
        repeat (4) tick;
        checks++;
        if ({tx_start, busy, rx_enable, drive_en} !== 4'b0010) begin
            failures++;
            $display("FAIL idle_after_reset: start=%b busy=%b rxen=%b drv=%b expected 0 0 1 0",
                     tx_start, busy, rx_enable, drive_en);
        end
    endtask

    task automatic test_info;
        run_txn(INFO, 0, 0, $urandom_range(2, 30), 1'b0);
    endtask

    task automatic test_status;
        run_txn(STATUS, 0, 0, 40, 1'b0);
    endtask

    task automatic test_line_low;
        run_txn(INFO, 5, 0, 10, 1'b0);
        repeat (3) run_txn(($urandom_range(0, 1) == 0) ? INFO : STATUS,
                           $urandom_range(1, 12), 0, $urandom_range(2, 20), 1'b0);
    endtask

    task automatic test_ready_stall;
        run_txn(STATUS, 0, $urandom_range(9, 20), 12, 1'b0);
        run_txn(INFO, $urandom_range(0, 4), $urandom_range(0, 15), 7, 1'b0);
    endtask

    task automatic test_timeout;
        run_txn(INFO, 0, 0, 0, 1'b0);
        repeat (20) tick;
        checks++;
        if (timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky: timeout_err=%b expected 1", timeout_err);
        end
        run_txn(STATUS, 0, 0, 9, 1'b0);
    endtask

    task automatic test_drop_requests;
        run_txn(STATUS, 0, 0, 20, 1'b1);
    endtask

    task automatic test_reset_mid_tx;
        int found;
        cur_read_state = INFO;
        found = 0;
        for (int i = 0; i < BOUND && found == 0; i++) begin
            tick;
            if (tx_start === 1'b1) found = 1;
        end
        cur_read_state = 4'h0;
        repeat (3) tick;
        checks++;
        if (found == 0 || drive_en !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_transmit: found=%0d drv=%b expected found=1 drv=1", found, drive_en);
        end
        reset = 1'b1;
        tick;
        checks++;
        if ({tx_start, tx_sel, tx_byte_count, drive_en, rx_enable, busy, timeout_err, resp_count} !==
            {1'b0, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL reset_mid_tx: start=%b sel=%b bytes=%0d drv=%b rxen=%b busy=%b terr=%b resp=%0d",
                     tx_start, tx_sel, tx_byte_count, drive_en, rx_enable, busy, timeout_err, resp_count);
        end
        tick;
        reset = 1'b0;
        exp_resp = 8'd0; exp_terr = 1'b0;
        repeat (4) tick;
    endtask

    task automatic test_back_to_back;
        for (int t = 0; t < 256; t++)
            run_txn(INFO, ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0, 0,
                    $urandom_range(2, 6), 1'b0);
        checks++;
        if (resp_count !== 8'd0) begin
            failures++;
            $display("FAIL resp_wrap: resp_count=%0d expected 0", resp_count);
        end
    endtask

    task automatic test_coincident;
        run_txn(INFO, 0, 0, TMO + 1, 1'b0);
    endtask

    initial begin
        test_reset;
        test_info;
        test_status;
        test_line_low;
        test_ready_stall;
        test_timeout;
        test_drop_requests;
        test_reset_mid_tx;
        test_back_to_back;
        test_coincident;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
